evaluate_sequencer: RTL
=======================

# evaluate_sequencer

Controller that shares one bank of `NUM_EVAL` fixed-latency board evaluators (bishops, knights, pawns, …) with a single requester. It accepts a board over a valid/ready handshake and drives the shared board bus and `board_valid` pulse. It waits for every evaluator's `eval_valid`, sums the signed midgame/endgame terms, presents the totals over a valid/ready handshake, and then issues `clear_eval` to re-arm the bank.

## Interface
- `EVAL_WIDTH`, default 0: width of each per-evaluator signed term. Must be set by the instantiating module.
- `NUM_EVAL`, default 4: number of evaluators in the bank. Legal range is 1..16.
- `TIMEOUT_CYCLES`, default 64: watchdog limit in the WAIT state. Used only with `EVAL_SEQ_TIMEOUT_EN`.
- `clk  input  1`: the only clock.
- `reset  input  1`: synchronous, active-high.
- `req_valid  input  1`: board request present.
- `req_board  input  BOARD_WIDTH`: board to evaluate.
- `req_ready  output  1`: sequencer can accept a request.
- `board  output  BOARD_WIDTH`: shared board bus to all evaluators.
- `board_valid  output  1`: single-cycle start pulse to all evaluators.
- `clear_eval  output  1`: single-cycle re-arm pulse to all evaluators.
- `eval_valid_in  input  NUM_EVAL`: per-evaluator done flags. Each flag holds high until `clear_eval`.
- `eval_mg_in  input  NUM_EVAL*EVAL_WIDTH`: packed signed midgame terms. Evaluator i occupies slice i.
- `eval_eg_in  input  NUM_EVAL*EVAL_WIDTH`: packed signed endgame terms, same packing.
- `result_valid  output  1`: totals available.
- `result_mg  output  EVAL_WIDTH+4`: signed midgame total.
- `result_eg  output  EVAL_WIDTH+4`: signed endgame total.
- `result_timeout  output  1`: the current result was forced by the watchdog.
- `result_ready  input  1`: consumer accepts the result.

## Operation
- States: IDLE, ISSUE, WAIT, PRESENT, CLEAR.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, register `req_board` into `board` and go to ISSUE.
- ISSUE:
  - `board_valid`=1 for exactly this cycle.
  - Go to WAIT.
- WAIT:
  - When all bits of `eval_valid_in` are high in the same cycle, register the sums into `result_mg`/`result_eg`.
  - Go to PRESENT.
  - Evaluator flags that go high early are not latched. The sum is captured only on the cycle where all flags are high together.
- PRESENT:
  - `result_valid`=1; the result outputs hold stable.
  - On `result_valid && result_ready`, go to CLEAR.
- CLEAR:
  - `clear_eval`=1 for exactly this cycle.
  - Go to IDLE.
- Arithmetic:
  - Each slice is sign-extended to EVAL_WIDTH+4 before summing.
  - For NUM_EVAL ≤ 16 no overflow is possible; no saturation is applied.
- `board` holds its value from acceptance until the next acceptance. It is never changed while any evaluator is busy.
- A request is never accepted outside IDLE. `req_ready` is low in ISSUE, WAIT, PRESENT and CLEAR.

## Timing
- Reset forces IDLE and sets all of the following to 0: `req_ready`, `board`, `board_valid`, `clear_eval`, `result_valid`, `result_mg`, `result_eg`, `result_timeout`.
  - `req_ready` rises in the first cycle after reset deasserts.
- Reset mid-operation abandons the transaction with no result and no `clear_eval`. Evaluators share the same reset, so the bank re-arms with it.
- Schedule for a request accepted at cycle 0, with evaluator latency L (cycles from `board_valid` to `eval_valid`):
  - `board_valid` at cycle 1.
  - All flags high at cycle 1+L.
  - `result_valid` at cycle 2+L.
- Once `result_ready` is seen at cycle P:
  - `clear_eval` at P+1.
  - `req_ready` at P+2.
- Minimum request spacing is L+4 cycles when `result_ready` is tied high.
- `result_ready` high while `result_valid` is low has no effect.
- Backpressure may last any number of cycles. Results and `board` stay constant throughout.
- `req_valid` asserted during the CLEAR cycle is accepted in the following IDLE cycle.

## Configuration
- `EVAL_SEQ_TIMEOUT_EN` defined:
  - A counter runs in WAIT, cleared on entry.
  - If it reaches `TIMEOUT_CYCLES` before all flags are high, go to PRESENT with `result_mg`=`result_eg`=0 and `result_timeout`=1.
  - The rest of the sequence (handshake, CLEAR) is unchanged.
  - `result_timeout` clears when the next transaction leaves WAIT normally.
- `EVAL_SEQ_TIMEOUT_EN` undefined:
  - No counter is built and WAIT waits indefinitely.
  - `result_timeout` is tied to 0.

## Test plan
- Sum and schedule: NUM_EVAL=3, EVAL_WIDTH=12, L=7; mg terms 100, -50, 7 and eg terms -2048, -2048, 2047. Required: `result_mg`=57, `result_eg`=-2049, `board_valid` at cycle 1, `result_valid` at cycle 9.
- Staggered completion: flags rise at cycles 3, 8 and 5 respectively. Required: sums captured only after cycle 8, `result_valid` at cycle 9.
- Backpressure: hold `result_ready` low for 20 cycles. Required: results stable, `req_ready`=0 throughout, `clear_eval` exactly one cycle after the handshake, then `req_ready`=1.
- Back-to-back: `req_valid` held high with two boards and `result_ready` tied high. Required: second `board_valid` exactly L+4 cycles after the first, and `board` unchanged during each WAIT.
- Reset in WAIT: assert `reset` at cycle 4. Required: every output 0 on the next cycle and no `result_valid`; a fresh request then completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=16): one flag never rises. Required: `result_valid` with `result_timeout`=1 and mg/eg=0 at cycle 18, `clear_eval` follows the handshake, and the next normal transaction returns `result_timeout`=0.

Source files
------------

// File: rtl/evaluate_sequencer.sv
// evaluate_sequencer
//
// Shares one bank of NUM_EVAL fixed-latency board evaluators with a single
// requester. One transaction runs at a time:
//   IDLE    -> accept a board (req_valid/req_ready), register it onto `board`
//   ISSUE   -> one-cycle `board_valid` start pulse to every evaluator
//   WAIT    -> wait until every `eval_valid_in` bit is high in the same cycle,
//              then register the sign-extended sums of the mg/eg terms
//   PRESENT -> hold the totals with `result_valid` until `result_ready`
//   CLEAR   -> one-cycle `clear_eval` pulse to re-arm the bank
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high; valid-side data is stable while waiting for ready.
//
// Optional feature: define EVAL_SEQ_TIMEOUT_EN to build a WAIT-state watchdog
// of TIMEOUT_CYCLES cycles. On expiry the result is forced to zero with
// `result_timeout` set. Without the macro WAIT waits indefinitely and
// `result_timeout` is tied low.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   req_valid/req_ready request handshake, req_board = board to evaluate
//   board, board_valid  shared board bus and start pulse to the evaluators
//   clear_eval          re-arm pulse to the evaluators
//   eval_valid_in       per-evaluator done flags (held until clear_eval)
//   eval_mg_in/eg_in    packed signed per-evaluator terms, slice i = eval i
//   result_*            totals handshake; result_timeout marks a forced result
//   dbg_state           current FSM state, for observation only

module evaluate_sequencer #(
    parameter int BOARD_WIDTH    = 64,
    parameter int EVAL_WIDTH     = 0,
    parameter int NUM_EVAL       = 4,
    parameter int TIMEOUT_CYCLES = 64,
    // Internal term width; clamps the unset default so the ports stay legal.
    localparam int EW = (EVAL_WIDTH > 0) ? EVAL_WIDTH : 1,
    localparam int RW = EW + 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [BOARD_WIDTH-1:0] req_board,
    output logic                   req_ready,
    output logic [BOARD_WIDTH-1:0] board,
    output logic                   board_valid,
    output logic                   clear_eval,
    input  logic [NUM_EVAL-1:0]    eval_valid_in,
    input  logic [NUM_EVAL*EW-1:0] eval_mg_in,
    input  logic [NUM_EVAL*EW-1:0] eval_eg_in,
    output logic                   result_valid,
    output logic [RW-1:0]          result_mg,
    output logic [RW-1:0]          result_eg,
    output logic                   result_timeout,
    input  logic                   result_ready,
    output logic [2:0]             dbg_state
);

    if ((NUM_EVAL < 1) || (NUM_EVAL > 16)) begin : g_bad_num_eval
        $error("evaluate_sequencer: NUM_EVAL must be in 1..16");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("evaluate_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_CLEAR   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [BOARD_WIDTH-1:0] board_q, board_d;
    logic [RW-1:0]          mg_q, mg_d;
    logic [RW-1:0]          eg_q, eg_d;
    logic                   timeout_q, timeout_d;
    // High in the cycle after any cycle with reset asserted; keeps req_ready
    // low until the first full cycle out of reset without a path from reset.
    logic                   rst_hold_q;

    logic                   all_valid;
    logic [RW-1:0]          mg_sum;
    logic [RW-1:0]          eg_sum;
    logic                   timeout_hit;

    assign all_valid = &eval_valid_in;

    // Sign-extend every slice to the result width before adding; with at
    // most 16 terms the four guard bits make overflow impossible.
    always_comb begin
        logic [EW-1:0] mg_term;
        logic [EW-1:0] eg_term;
        mg_sum  = '0;
        eg_sum  = '0;
        mg_term = '0;
        eg_term = '0;
        for (int i = 0; i < NUM_EVAL; i++) begin
            mg_term = eval_mg_in[i*EW +: EW];
            eg_term = eval_eg_in[i*EW +: EW];
            mg_sum  = mg_sum + {{4{mg_term[EW-1]}}, mg_term};
            eg_sum  = eg_sum + {{4{eg_term[EW-1]}}, eg_term};
        end
    end

`ifdef EVAL_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    // Cleared in ISSUE so it reads 0 on the first WAIT cycle; the watchdog
    // fires on the WAIT cycle whose increment would reach TIMEOUT_CYCLES.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == S_ISSUE) begin
            wait_cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign result_timeout = timeout_q;
`else
    assign timeout_hit    = 1'b0;
    assign result_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        mg_d      = mg_q;
        eg_d      = eg_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !rst_hold_q) begin
                    board_d = req_board;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A normal completion wins over a watchdog expiry in the
                // same cycle.
                if (all_valid) begin
                    mg_d      = mg_sum;
                    eg_d      = eg_sum;
                    timeout_d = 1'b0;
                    state_d   = S_PRESENT;
                end else if (timeout_hit) begin
                    mg_d      = '0;
                    eg_d      = '0;
                    timeout_d = 1'b1;
                    state_d   = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (result_ready) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            board_q   <= '0;
            mg_q      <= '0;
            eg_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            mg_q      <= mg_d;
            eg_q      <= eg_d;
            timeout_q <= timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        rst_hold_q <= reset;
    end

    assign req_ready    = (state_q == S_IDLE) && !rst_hold_q;
    assign board        = board_q;
    assign board_valid  = (state_q == S_ISSUE);
    assign clear_eval   = (state_q == S_CLEAR);
    assign result_valid = (state_q == S_PRESENT);
    assign result_mg    = mg_q;
    assign result_eg    = eg_q;
    assign dbg_state    = state_q;

endmodule
